// File: rtl/perm_gen.sv
// rtl/perm_gen.sv - lexicographic permutation enumerator on a valid/ready stream
// Optional perm_index output enabled by defining PERM_GEN_INDEX_EN.
module perm_gen #(
  parameter int N     = 8,
  parameter int W     = $clog2(N),
  parameter int IDX_W = 16
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           start,
  input  logic           abort,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] perm,
  output logic           out_first,
  output logic           out_last,
  output logic           busy,
  output logic           done
`ifdef PERM_GEN_INDEX_EN
  ,
  output logic [IDX_W-1:0] perm_index
`endif
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t       state_q, state_d;
  logic [W-1:0] p_q   [N];
  logic [W-1:0] p_d   [N];
  logic [W-1:0] nxt   [N];
  logic [W-1:0] ident [N];
  logic         first_q, first_d;
  logic         done_q, done_d;
  logic         has_piv;
  int           piv, kx;
  logic [W-1:0] pv, best;
  logic         hs;

  // Successor: pivot, smallest larger element in the suffix, swap, reverse suffix.
  always_comb begin
    has_piv = 1'b0;
    piv     = 0;
    for (int j = 0; j < N-1; j++)
      if (p_q[j] < p_q[j+1]) begin
        has_piv = 1'b1;
        piv     = j;
      end
    pv = p_q[0];
    for (int j = 0; j < N; j++)
      if (j == piv) pv = p_q[j];
    best = '1;
    kx   = piv + 1;
    for (int j = 0; j < N; j++)
      if (j > piv && p_q[j] > pv && p_q[j] <= best) begin
        best = p_q[j];
        kx   = j;
      end
    for (int j = 0; j < N; j++) begin
      ident[j] = W'(j);
      nxt[j]   = p_q[j];
      if (j == piv)
        nxt[j] = best;
      else if (j > piv)
        for (int m = 0; m < N; m++)
          if (m == N + piv - j) nxt[j] = (m == kx) ? pv : p_q[m];
    end
  end

  assign hs = (state_q == EMIT) && out_ready && !abort;

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    first_d = first_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = EMIT;
          p_d     = ident;
          first_d = 1'b1;
        end
      end
      EMIT: begin
        if (abort) begin
          state_d = IDLE;
          p_d     = ident;
          first_d = 1'b0;
        end else if (out_ready) begin
          first_d = 1'b0;
          if (has_piv) begin
            p_d = nxt;
          end else begin
            state_d = IDLE;
            p_d     = ident;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      p_q     <= ident;
      first_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      first_q <= first_d;
      done_q  <= done_d;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign perm[g*W +: W] = p_q[g];
  end

  assign out_valid = (state_q == EMIT);
  assign busy      = (state_q == EMIT);
  assign out_last  = (state_q == EMIT) && !has_piv;
  assign out_first = first_q;
  assign done      = done_q;

`ifdef PERM_GEN_INDEX_EN
  logic [IDX_W-1:0] idx_q;
  always_ff @(posedge CLK) begin
    if (RST || state_q != EMIT || abort || (hs && !has_piv))
      idx_q <= '0;
    else if (hs)
      idx_q <= idx_q + 1'b1;
  end
  assign perm_index = idx_q;
`endif

endmodule

// File: tb/tb_perm_gen.sv
// tb/tb_perm_gen.sv - randomized check of perm_gen (N=4 and N=8) against a factorial-rank model
module tb_perm_gen;

  localparam int NA  = 4;
  localparam int WA  = 2;
  localparam int NFA = 24;
  localparam int NB  = 8;
  localparam int WB  = 3;
  localparam int NFB = 40320;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0, abort_a = 1'b0, ready_a = 1'b0;
  logic start_b = 1'b0, abort_b = 1'b0, ready_b = 1'b1;
  logic valid_a, first_a, last_a, busy_a, done_a;
  logic valid_b, first_b, last_b, busy_b, done_b;
  logic [NA*WA-1:0] perm_a;
  logic [NB*WB-1:0] perm_b;
`ifdef PERM_GEN_INDEX_EN
  logic [15:0] pidx_a, pidx_b;
`endif

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  perm_gen #(.N(NA), .W(WA), .IDX_W(16)) dut_a (
    .CLK(clk), .RST(rst), .start(start_a), .abort(abort_a),
    .out_valid(valid_a), .out_ready(ready_a), .perm(perm_a),
    .out_first(first_a), .out_last(last_a), .busy(busy_a), .done(done_a)
`ifdef PERM_GEN_INDEX_EN
    , .perm_index(pidx_a)
`endif
  );

  perm_gen #(.N(NB), .W(WB), .IDX_W(16)) dut_b (
    .CLK(clk), .RST(rst), .start(start_b), .abort(abort_b),
    .out_valid(valid_b), .out_ready(ready_b), .perm(perm_b),
    .out_first(first_b), .out_last(last_b), .busy(busy_b), .done(done_b)
`ifdef PERM_GEN_INDEX_EN
    , .perm_index(pidx_b)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // k-th permutation in lexicographic order via factorial-base digits.
  function automatic logic [63:0] kth(input int n, input int w, input int k);
    int avail[$];
    int f, d, kk;
    logic [63:0] r;
    r  = '0;
    kk = k;
    for (int i = 0; i < n; i++) avail.push_back(i);
    for (int pos = 0; pos < n; pos++) begin
      f = 1;
      for (int i = 2; i < n - pos; i++) f *= i;
      d  = kk / f;
      kk = kk % f;
      r  = r | (64'(avail[d]) << (pos * w));
      avail.delete(d);
    end
    return r;
  endfunction

  function automatic logic [63:0] pack8(input int e[8]);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = r | (64'(e[i]) << (i * WB));
    return r;
  endfunction

  task automatic check_idle_a(input string tag, input logic exp_done);
    check_eq({tag, "_valid"}, valid_a, 0);
    check_eq({tag, "_busy"},  busy_a,  0);
    check_eq({tag, "_first"}, first_a, 0);
    check_eq({tag, "_last"},  last_a,  0);
    check_eq({tag, "_done"},  done_a,  exp_done);
    check_eq({tag, "_perm"},  perm_a,  kth(NA, WA, 0));
  endtask

  // One enumeration on dut_a; abort_at / rst_at of -1 disable that event.
  task automatic run_a(input int abort_at, input bit rand_rdy, input int rst_at);
    int  k   = 0;
    int  cyc = 0;
    bit  fin = 0;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    while (!fin) begin
      cyc++;
      if (cyc > 2000) begin
        check_eq("a_timeout", 1, 0);
        fin = 1;
      end else begin
        check_eq("a_valid", valid_a, 1);
        check_eq("a_busy",  busy_a,  1);
        check_eq("a_perm",  perm_a,  kth(NA, WA, k));
        check_eq("a_first", first_a, k == 0);
        check_eq("a_last",  last_a,  k == NFA - 1);
        check_eq("a_done",  done_a,  0);
`ifdef PERM_GEN_INDEX_EN
        check_eq("a_index", pidx_a, k);
`endif
        abort_a = (k == abort_at);
        rst     = (k == rst_at);
        ready_a = (abort_a || !rand_rdy) ? 1'b1 : 1'($urandom_range(0, 1));
        start_a = 1'($urandom_range(0, 1));
        @(negedge clk);
        start_a = 1'b0;
        if (rst) begin
          rst = 1'b0;
          check_idle_a("a_rst", 0);
          fin = 1;
        end else if (abort_a) begin
          abort_a = 1'b0;
          check_idle_a("a_abort", 0);
          @(negedge clk);
          check_idle_a("a_abort2", 0);
          fin = 1;
        end else if (ready_a) begin
          if (k == NFA - 1) begin
            check_idle_a("a_end", 1);
            @(negedge clk);
            check_idle_a("a_end2", 0);
            fin = 1;
          end else begin
            k++;
          end
        end
      end
    end
    ready_a = 1'b0;
  endtask

  task automatic run_b();
    int k = 0;
    int e[8];
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    while (valid_b === 1'b1 && k < NFB + 10) begin
      check_eq("b_perm", perm_b, kth(NB, WB, k));
      check_eq("b_last", last_b, k == NFB - 1);
      if (k == 1) begin
        e = '{0, 1, 2, 3, 4, 5, 7, 6};
        check_eq("b_beat1", perm_b, pack8(e));
      end
      if (k == 2) begin
        e = '{0, 1, 2, 3, 4, 6, 5, 7};
        check_eq("b_beat2", perm_b, pack8(e));
      end
      if (k == NFB - 1) begin
        e = '{7, 6, 5, 4, 3, 2, 1, 0};
        check_eq("b_final", perm_b, pack8(e));
`ifdef PERM_GEN_INDEX_EN
        check_eq("b_index", pidx_b, NFB - 1);
`endif
      end
      k++;
      @(negedge clk);
    end
    check_eq("b_count", k, NFB);
    check_eq("b_done",  done_b, 1);
    @(negedge clk);
    check_eq("b_done_pulse", done_b, 0);
    check_eq("b_valid_end",  valid_b, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_a("reset", 0);
    check_eq("reset_b_valid", valid_b, 0);
    check_eq("reset_b_perm",  perm_b,  kth(NB, WB, 0));
    rst = 1'b0;

    run_a(-1, 0, -1);
    run_a(-1, 1, -1);
    run_a(-1, 1, -1);
    run_a(10, 0, -1);
    run_a(-1, 0, -1);

    @(negedge clk);
    start_a = 1'b1;
    abort_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    abort_a = 1'b0;
    check_idle_a("start_abort", 0);

    run_a(-1, 1, 7);
    run_a(-1, 1, 30);
    run_a(3, 1, -1);

    run_b();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
